// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU datapath and a DMA/debug port.
package dmem_pkg;

  localparam int WORD_BYTES         = 8;
  localparam int WORD_SHIFT         = $clog2(WORD_BYTES);
  localparam int DEF_MAX_BURST      = 4;
  localparam int DEF_STARVE_LIMIT   = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DMA_XFER = 2'd1,
    CPU_TURN = 2'd2
  } arb_state_e;

  // Byte address of a burst beat; wraps silently past the top of the 64-bit space.
  function automatic logic [63:0] beat_addr(input logic [63:0] base, input logic [63:0] beat);
    return base + (beat << WORD_SHIFT);
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve.sv
// Saturating wait counter for a pending DMA request; clear has priority over increment.
module dmem_arbiter_starve #(
  parameter int LIMIT = 8
) (
  input  logic CLK,
  input  logic resetl,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  assign at_limit = (cnt == CW'(LIMIT - 1));

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single DataMemory port between the CPU datapath and bursting DMA requester.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | CPU owns the port; DMA request waits or is counted as starved
// DMA_XFER | DMA owns the port, one 64-bit beat per cycle
// CPU_TURN | guaranteed CPU cycle after every burst; no grant possible
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int LW          = $clog2(MAX_BURST)
) (
  input  logic          CLK,
  input  logic          resetl,
  input  logic          cpu_memread,
  input  logic          cpu_memwrite,
  input  logic [63:0]   cpu_addr,
  input  logic [63:0]   cpu_wdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [63:0]   dma_addr,
  input  logic [LW-1:0] dma_len,
  input  logic [63:0]   dma_wdata,
  output logic          dma_gnt,
  output logic [LW-1:0] dma_beat_idx,
  output logic          dma_done,
  output logic [63:0]   dma_rdata,
  output logic [63:0]   mem_addr,
  output logic [63:0]   mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [63:0]   mem_rdata
);

  arb_state_e    state;
  logic [63:0]   base_q;
  logic [LW-1:0] beat_cnt;
  logic [LW-1:0] len_q;
  logic          we_q;

  logic cpu_access;
  logic in_idle;
  logic in_xfer;
  logic starve_hit;
  logic start;
  logic last_beat;

  assign cpu_access = cpu_memread | cpu_memwrite;
  assign in_idle    = (state == IDLE);
  assign in_xfer    = (state == DMA_XFER);
  assign start      = in_idle && dma_req && (!cpu_access || starve_hit);
  assign last_beat  = in_xfer && (beat_cnt == len_q);

  // Counter only advances while a request loses in IDLE; CPU_TURN and bursts hold it.
  dmem_arbiter_starve #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .CLK      (CLK),
    .resetl   (resetl),
    .clr      (in_idle && (!dma_req || start)),
    .inc      (in_idle && dma_req && cpu_access),
    .at_limit (starve_hit)
  );

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state    <= IDLE;
      base_q   <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= DMA_XFER;
            base_q   <= dma_addr;
            len_q    <= dma_len;
            we_q     <= dma_we;
            beat_cnt <= '0;
          end
        end
        DMA_XFER: begin
          if (last_beat) begin
            state <= CPU_TURN;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        CPU_TURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are gated by resetl so nothing reaches memory while reset is held.
  always_comb begin
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    cpu_stall    = 1'b0;
    dma_gnt      = 1'b0;
    dma_done     = 1'b0;
    dma_beat_idx = '0;
    if (in_xfer) begin
      mem_addr     = beat_addr(base_q, 64'(beat_cnt));
      mem_wdata    = dma_wdata;
      mem_read     = resetl & ~we_q;
      mem_write    = resetl & we_q;
      cpu_stall    = resetl & cpu_access;
      dma_gnt      = resetl;
      dma_done     = resetl & last_beat;
      dma_beat_idx = beat_cnt;
    end else begin
      mem_read  = resetl & cpu_memread;
      mem_write = resetl & cpu_memwrite;
    end
  end

  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural DataMemory attached.
module tb_dmem_arbiter;

  logic        CLK;
  logic        resetl;
  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [63:0] dma_addr;
  logic [1:0]  dma_len;
  logic [63:0] dma_wdata;
  logic        dma_gnt;
  logic [1:0]  dma_beat_idx;
  logic        dma_done;
  logic [63:0] dma_rdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_rdata;

  logic [63:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter dut (
    .CLK          (CLK),
    .resetl       (resetl),
    .cpu_memread  (cpu_memread),
    .cpu_memwrite (cpu_memwrite),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_len      (dma_len),
    .dma_wdata    (dma_wdata),
    .dma_gnt      (dma_gnt),
    .dma_beat_idx (dma_beat_idx),
    .dma_done     (dma_done),
    .dma_rdata    (dma_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  assign mem_rdata = mem[mem_addr[10:3]];

  always @(posedge CLK) begin
    if (mem_write) mem[mem_addr[10:3]] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    resetl       = 1'b0;
    cpu_memread  = 1'b1;
    cpu_memwrite = 1'b1;
    cpu_addr     = 64'h40;
    cpu_wdata    = 64'h55;
    dma_req      = 1'b0;
    dma_we       = 1'b0;
    dma_addr     = '0;
    dma_len      = '0;
    dma_wdata    = '0;

    #1;
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_gnt", 64'(dma_gnt), 64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_done", 64'(dma_done), 64'd0);

    next_cycle();
    resetl       = 1'b1;
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;

    // CPU-only traffic passes straight through
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      cpu_memread = 1'b1;
      cpu_addr    = 64'h300 + 64'(8 * i);
      #1;
      chk("pass_addr", mem_addr, 64'h300 + 64'(8 * i));
      chk("pass_read", 64'(mem_read), 64'd1);
      chk("pass_write", 64'(mem_write), 64'd0);
      chk("pass_stall", 64'(cpu_stall), 64'd0);
      chk("pass_gnt", 64'(dma_gnt), 64'd0);
    end
    next_cycle();
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b1;
    cpu_addr     = 64'h200;
    cpu_wdata    = 64'hDEADBEEF;
    #1;
    chk("store_write", 64'(mem_write), 64'd1);
    chk("store_read", 64'(mem_read), 64'd0);
    chk("store_addr", mem_addr, 64'h200);
    chk("store_wdata", mem_wdata, 64'hDEADBEEF);

    // Uncontended 4-beat write burst at 0x100
    next_cycle();
    cpu_memwrite = 1'b0;
    dma_req      = 1'b1;
    dma_we       = 1'b1;
    dma_addr     = 64'h100;
    dma_len      = 2'd3;
    dma_wdata    = 64'h1000;
    #1;
    chk("b_req_cycle_gnt", 64'(dma_gnt), 64'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      dma_req   = 1'b0;
      dma_addr  = 64'hBAD0;
      dma_len   = 2'd0;
      dma_we    = 1'b0;
      dma_wdata = 64'h1000 + 64'(k);
      #1;
      chk("b_gnt", 64'(dma_gnt), 64'd1);
      chk("b_addr", mem_addr, 64'h100 + 64'(8 * k));
      chk("b_write", 64'(mem_write), 64'd1);
      chk("b_read", 64'(mem_read), 64'd0);
      chk("b_wdata", mem_wdata, 64'h1000 + 64'(k));
      chk("b_beat_idx", 64'(dma_beat_idx), 64'(k));
      chk("b_done", 64'(dma_done), (k == 3) ? 64'd1 : 64'd0);
      chk("b_stall", 64'(cpu_stall), 64'd0);
    end
    next_cycle();
    dma_req = 1'b1;
    #1;
    chk("b_turn_gnt", 64'(dma_gnt), 64'd0);
    chk("b_turn_write", 64'(mem_write), 64'd0);
    next_cycle();
    #1;
    chk("b_idle_after_turn_gnt", 64'(dma_gnt), 64'd0);
    dma_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      cpu_memread = 1'b1;
      cpu_addr    = 64'h100 + 64'(8 * k);
      #1;
      chk("b_readback", dma_rdata, 64'h1000 + 64'(k));
    end

    // Starvation: CPU loads every cycle; request forced in on the 9th cycle, twice
    dma_we   = 1'b0;
    dma_addr = 64'h100;
    dma_len  = 2'd1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) begin
        next_cycle();
        dma_req  = (r == 0) ? 1'b1 : dma_req;
        cpu_addr = 64'h400 + 64'(8 * c);
        #1;
        chk("s_wait_gnt", 64'(dma_gnt), 64'd0);
        chk("s_wait_addr", mem_addr, 64'h400 + 64'(8 * c));
        chk("s_wait_stall", 64'(cpu_stall), 64'd0);
      end
      for (int k = 0; k < 2; k++) begin
        next_cycle();
        if (r == 1) dma_req = 1'b0;
        #1;
        chk("s_gnt", 64'(dma_gnt), 64'd1);
        chk("s_stall", 64'(cpu_stall), 64'd1);
        chk("s_addr", mem_addr, 64'h100 + 64'(8 * k));
        chk("s_read", 64'(mem_read), 64'd1);
        chk("s_rdata", dma_rdata, 64'h1000 + 64'(k));
        chk("s_done", 64'(dma_done), (k == 1) ? 64'd1 : 64'd0);
      end
      next_cycle();
      #1;
      chk("s_turn_gnt", 64'(dma_gnt), 64'd0);
      chk("s_turn_stall", 64'(cpu_stall), 64'd0);
      chk("s_turn_addr", mem_addr, 64'h438);
    end

    // Single-beat read of pre-loaded 0x200
    next_cycle();
    cpu_memread = 1'b0;
    dma_req     = 1'b1;
    dma_we      = 1'b0;
    dma_addr    = 64'h200;
    dma_len     = 2'd0;
    #1;
    chk("d_req_cycle_gnt", 64'(dma_gnt), 64'd0);
    next_cycle();
    dma_req = 1'b0;
    #1;
    chk("d_gnt", 64'(dma_gnt), 64'd1);
    chk("d_done", 64'(dma_done), 64'd1);
    chk("d_beat_idx", 64'(dma_beat_idx), 64'd0);
    chk("d_read", 64'(mem_read), 64'd1);
    chk("d_addr", mem_addr, 64'h200);
    chk("d_rdata", dma_rdata, 64'hDEADBEEF);
    next_cycle();
    #1;
    chk("d_turn_gnt", 64'(dma_gnt), 64'd0);

    // Address wrap at the top of the 64-bit space
    next_cycle();
    dma_req  = 1'b1;
    dma_addr = 64'hFFFF_FFFF_FFFF_FFF8;
    dma_len  = 2'd1;
    next_cycle();
    dma_req = 1'b0;
    #1;
    chk("w_addr0", mem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("w_done0", 64'(dma_done), 64'd0);
    next_cycle();
    #1;
    chk("w_addr1", mem_addr, 64'h0);
    chk("w_done1", 64'(dma_done), 64'd1);
    chk("w_beat_idx1", 64'(dma_beat_idx), 64'd1);
    next_cycle();

    // Reset during beat 2 of a 4-beat write over 0x100
    next_cycle();
    dma_req  = 1'b1;
    dma_we   = 1'b1;
    dma_addr = 64'h100;
    dma_len  = 2'd3;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      dma_req   = 1'b0;
      dma_wdata = 64'h2000 + 64'(k);
      #1;
      chk("r_write", 64'(mem_write), 64'd1);
      chk("r_addr", mem_addr, 64'h100 + 64'(8 * k));
    end
    next_cycle();
    dma_wdata = 64'h2002;
    #1;
    chk("r_beat2_write", 64'(mem_write), 64'd1);
    #1;
    resetl = 1'b0;
    #1;
    chk("r_rst_write", 64'(mem_write), 64'd0);
    chk("r_rst_read", 64'(mem_read), 64'd0);
    chk("r_rst_gnt", 64'(dma_gnt), 64'd0);
    chk("r_rst_done", 64'(dma_done), 64'd0);
    chk("r_rst_stall", 64'(cpu_stall), 64'd0);
    next_cycle();
    chk("r_rst_hold_gnt", 64'(dma_gnt), 64'd0);
    resetl = 1'b1;
    next_cycle();
    #1;
    chk("r_idle_gnt", 64'(dma_gnt), 64'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      cpu_memread = 1'b1;
      cpu_addr    = 64'h100 + 64'(8 * k);
      #1;
      chk("r_readback", dma_rdata, (k < 2) ? (64'h2000 + 64'(k)) : (64'h1000 + 64'(k)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
